fetch_unit: RTL and testbench

- Instruction fetch stage of the non-pipelined RV32I core; the block at the other end of the execute stage's pc/pc_next interface.
- Owns the architectural PC and fetches one instruction at a time from instruction memory over a req/gnt/rvalid handshake.
- Hands {inst, pc} to decode over a valid/ready handshake, then waits for execute's resolved pc_next before fetching again.
- Flags misaligned next-PC targets.

---
 rtl/fetch_unit.sv | 88 ++++++++
 tb/tb_fetch_unit.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage for the non-pipelined RV32I core.
// Fetches one instruction per PC from instruction memory, hands it to decode,
// then waits for the resolved next PC from execute before fetching again.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pc_next_valid,
    input  logic [31:0] pc_next,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] pc,
    output logic        misalign_err,
    output logic [31:0] fetch_count
);

    typedef enum logic [2:0] {
        S_REQ   = 3'd0,
        S_WAIT  = 3'd1,
        S_ISSUE = 3'd2,
        S_NEXT  = 3'd3,
        S_HALT  = 3'd4
    } state_t;

    state_t state;

    // Fetch sequencing: request, await response, issue to decode, await next PC.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_REQ;
            pc           <= RESET_PC;
            inst         <= 32'h0;
            misalign_err <= 1'b0;
            fetch_count  <= 32'h0;
        end else begin
            case (state)
                // rvalid deliberately ignored here so stale responses are dropped
                S_REQ: begin
                    if (imem_gnt) begin
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem_rvalid) begin
                        inst  <= imem_rdata;
                        state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (inst_ready) begin
                        fetch_count <= fetch_count + 32'd1;
                        state       <= S_NEXT;
                    end
                end
                S_NEXT: begin
                    if (pc_next_valid) begin
                        if (pc_next[1:0] == 2'b00) begin
                            pc    <= pc_next;
                            state <= S_REQ;
                        end else begin
                            misalign_err <= 1'b1;
                            state        <= S_HALT;
                        end
                    end
                end
                S_HALT: begin
                    state <= S_HALT;
                end
                default: begin
                    state <= S_HALT;
                end
            endcase
        end
    end

    // Handshake strobes decode straight from state; reset suppresses them immediately.
    assign imem_req   = (state == S_REQ) && !rst;
    assign inst_valid = (state == S_ISSUE) && !rst;
    assign imem_addr  = pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed + randomized bench for fetch_unit with a transaction-level reference model.
module tb_fetch_unit;

    logic        clk;
    logic        rst;
    logic        pc_next_valid;
    logic [31:0] pc_next;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] pc;
    logic        misalign_err;
    logic [31:0] fetch_count;

    int total;
    int bad;

    // Reference model: architectural state as seen from the interfaces
    logic [31:0] m_pc;
    logic [31:0] m_count;
    logic        m_err;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    fetch_unit #(.RESET_PC(RESET_PC)) dut (
        .clk          (clk),
        .rst          (rst),
        .pc_next_valid(pc_next_valid),
        .pc_next      (pc_next),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_gnt     (imem_gnt),
        .imem_rvalid  (imem_rvalid),
        .imem_rdata   (imem_rdata),
        .inst_valid   (inst_valid),
        .inst_ready   (inst_ready),
        .inst         (inst),
        .pc           (pc),
        .misalign_err (misalign_err),
        .fetch_count  (fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Synchronous reset for two edges, then verify reset state and first request
    task automatic do_reset();
        rst = 1'b1;
        tick();
        chk("rst_req_forced0", 32'(imem_req), 32'd0);
        chk("rst_ivalid_forced0", 32'(inst_valid), 32'd0);
        tick();
        chk("rst_pc", pc, RESET_PC);
        chk("rst_inst", inst, 32'h0);
        chk("rst_count", fetch_count, 32'h0);
        chk("rst_err", 32'(misalign_err), 32'd0);
        rst = 1'b0;
        #1;
        m_pc    = RESET_PC;
        m_count = 32'h0;
        m_err   = 1'b0;
        chk("post_rst_req", 32'(imem_req), 32'd1);
        chk("post_rst_addr", imem_addr, RESET_PC);
    endtask

    // One full fetch starting in REQ; ends in NEXT after decode accepts
    task automatic fetch_one(input int gd, input int rd, input logic [31:0] data,
                             input int stall, input bit poke);
        chk("req_start", 32'(imem_req), 32'd1);
        chk("addr_start", imem_addr, m_pc);
        chk("ivalid_in_req", 32'(inst_valid), 32'd0);
        for (int i = 0; i < gd; i++) begin
            tick();
            chk("req_held", 32'(imem_req), 32'd1);
            chk("addr_stable", imem_addr, m_pc);
        end
        imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0;
        for (int i = 1; i < rd; i++) begin
            inst_ready    = 1'b1;
            pc_next_valid = poke;
            pc_next       = 32'h0000_0003;
            imem_gnt      = 1'b1;
            chk("wait_no_req", 32'(imem_req), 32'd0);
            chk("wait_no_ivalid", 32'(inst_valid), 32'd0);
            tick();
        end
        inst_ready    = 1'b0;
        imem_gnt      = 1'b0;
        pc_next_valid = 1'b0;
        chk("wait_no_req2", 32'(imem_req), 32'd0);
        imem_rvalid = 1'b1;
        imem_rdata  = data;
        tick();
        imem_rvalid = 1'b0;
        imem_rdata  = $urandom;
        chk("issue_valid", 32'(inst_valid), 32'd1);
        chk("issue_inst", inst, data);
        chk("issue_pc", pc, m_pc);
        for (int i = 0; i < stall; i++) begin
            pc_next_valid = poke;
            pc_next       = 32'h0000_0003;
            tick();
            pc_next_valid = 1'b0;
            chk("stall_valid", 32'(inst_valid), 32'd1);
            chk("stall_inst", inst, data);
            chk("stall_pc", pc, m_pc);
            chk("stall_count", fetch_count, m_count);
            chk("stall_err", 32'(misalign_err), 32'(m_err));
        end
        inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0;
        m_count = m_count + 32'd1;
        chk("accept_valid", 32'(inst_valid), 32'd0);
        chk("accept_count", fetch_count, m_count);
        chk("accept_req", 32'(imem_req), 32'd0);
        chk("accept_pc", pc, m_pc);
    endtask

    // Deliver execute's next PC while in NEXT
    task automatic redirect(input logic [31:0] target);
        pc_next_valid = 1'b1;
        pc_next       = target;
        tick();
        pc_next_valid = 1'b0;
        pc_next       = $urandom;
        if (target[1:0] == 2'b00) begin
            m_pc = target;
            chk("redir_req", 32'(imem_req), 32'd1);
            chk("redir_addr", imem_addr, target);
        end else begin
            m_err = 1'b1;
            chk("misalign_err", 32'(misalign_err), 32'd1);
            chk("misalign_noreq", 32'(imem_req), 32'd0);
            chk("misalign_pc", pc, m_pc);
        end
    endtask

    initial begin
        logic [31:0] tgt;
        total         = 0;
        bad           = 0;
        rst           = 1'b1;
        pc_next_valid = 1'b0;
        pc_next       = 32'h0;
        imem_gnt      = 1'b0;
        imem_rvalid   = 1'b0;
        imem_rdata    = 32'h0;
        inst_ready    = 1'b0;
        m_pc          = RESET_PC;
        m_count       = 32'h0;
        m_err         = 1'b0;

        // Reset and first fetch at RESET_PC
        do_reset();
        fetch_one(0, 1, 32'h0050_0093, 0, 1'b0);

        // Sequential fetch with a 5-cycle decode stall and early next-PC pulses
        redirect(m_pc + 32'd4);
        fetch_one(0, 1, $urandom, 5, 1'b1);

        // Unit must still be waiting in NEXT: no request, no issue
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("next_idle_req", 32'(imem_req), 32'd0);
            chk("next_idle_ivalid", 32'(inst_valid), 32'd0);
        end

        // Branch redirect followed by memory wait-states
        redirect(32'h0000_0040);
        fetch_one(3, 2, $urandom, 1, 1'b0);

        // Randomized sequence with a wrapping PC thrown in
        for (int n = 0; n < 12; n++) begin
            case ($urandom_range(0, 2))
                0:       tgt = m_pc + 32'd4;
                1:       tgt = {$urandom, 2'b00} >> 0;
                default: tgt = {m_pc[31:12], 12'h0} + {20'h0, 10'($urandom), 2'b00};
            endcase
            if (n == 5) tgt = 32'hFFFF_FFFC;
            if (n == 6) tgt = m_pc + 32'd4;
            tgt[1:0] = 2'b00;
            redirect(tgt);
            fetch_one($urandom_range(0, 3), $urandom_range(1, 3), $urandom,
                      $urandom_range(0, 3), 1'(($urandom_range(0, 1))));
        end
        chk("wrap_seen_pc", pc, m_pc);

        // Reset during WAIT; response lands on the first post-reset cycle
        redirect(32'h0000_0100);
        imem_gnt = 1'b1;
        tick();
        imem_gnt    = 1'b0;
        rst         = 1'b1;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hDEAD_BEEF;
        tick();
        rst = 1'b0;
        #1;
        m_pc    = RESET_PC;
        m_count = 32'h0;
        m_err   = 1'b0;
        chk("rstwait_count", fetch_count, 32'h0);
        chk("rstwait_req", 32'(imem_req), 32'd1);
        chk("rstwait_addr", imem_addr, RESET_PC);
        tick();
        imem_rvalid = 1'b0;
        chk("stale_ivalid", 32'(inst_valid), 32'd0);
        chk("stale_req", 32'(imem_req), 32'd1);
        chk("stale_inst", inst, 32'h0);
        fetch_one(1, 1, 32'h0010_0113, 0, 1'b0);

        // Misaligned JALR target halts the unit until reset
        redirect(32'h0000_0042);
        for (int i = 0; i < 20; i++) begin
            imem_gnt      = 1'($urandom_range(0, 1));
            imem_rvalid   = 1'($urandom_range(0, 1));
            inst_ready    = 1'($urandom_range(0, 1));
            pc_next_valid = 1'($urandom_range(0, 1));
            pc_next       = {$urandom, 2'b00} >> 0;
            tick();
            chk("halt_req", 32'(imem_req), 32'd0);
            chk("halt_ivalid", 32'(inst_valid), 32'd0);
            chk("halt_err", 32'(misalign_err), 32'd1);
            chk("halt_count", fetch_count, m_count);
        end
        imem_gnt      = 1'b0;
        imem_rvalid   = 1'b0;
        inst_ready    = 1'b0;
        pc_next_valid = 1'b0;
        do_reset();
        fetch_one(0, 1, 32'h0000_0013, 0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
